// File: rtl/vending_pkg.sv
// vending_pkg: shared FSM states and coin constants for the vending controller
package vending_pkg;
  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;
  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_MAX = 2'd3;
endpackage

// File: rtl/vending_stock.sv
// vending_stock: per-item stock counters with restock, indexed decrement and empty flags
module vending_stock #(
  parameter int N_ITEMS = 8,
  parameter int STOCK_W = 4,
  parameter int INIT_STOCK = 4,
  parameter int IDX_W = $clog2(N_ITEMS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restock,
  input  logic               dec,
  input  logic [IDX_W-1:0]   dec_idx,
  output logic [N_ITEMS-1:0] empty
);
  for (genvar i = 0; i < N_ITEMS; i++) begin : g_item
    logic [STOCK_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst)
      if (!rst) cnt <= STOCK_W'(INIT_STOCK);
      else if (restock) cnt <= STOCK_W'(INIT_STOCK);
      else if (dec && 32'(dec_idx) == i && cnt != '0) cnt <= cnt - STOCK_W'(1);
    assign empty[i] = cnt == '0;
  end
endmodule

// File: rtl/vending_ctrl.sv
// vending_ctrl: coin credit, item select against price/stock, vend and per-unit change FSM
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int N_ITEMS = 8,
  parameter int CREDIT_W = 8,
  parameter int STOCK_W = 4,
  parameter int INIT_STOCK = 4,
  parameter int TIMEOUT_CYC = 1000,
  localparam int IDX_W = $clog2(N_ITEMS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  coin_in,
  input  logic                        select_valid,
  input  logic [IDX_W-1:0]            select_item,
  input  logic [N_ITEMS*CREDIT_W-1:0] price_flat,
  input  logic                        cancel,
  input  logic                        restock,
  output logic                        dispense,
  output logic [IDX_W-1:0]            dispense_item,
  output logic                        return_change,
  output logic                        coin_reject,
  output logic                        sel_reject,
  output logic [CREDIT_W-1:0]         credit,
  output logic                        busy
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t state, state_d;
  logic [CREDIT_W-1:0] credit_d, sel_price;
  logic [CREDIT_W-1:0] price [N_ITEMS];
  logic [CREDIT_W:0] sum;
  logic [TW-1:0] tmr, tmr_d;
  logic [N_ITEMS-1:0] empty;
  logic coin, fits, idx_ok, sel_ok, act, coin_rej_d, sel_rej_d;

  for (genvar i = 0; i < N_ITEMS; i++) begin : g_price
    assign price[i] = price_flat[i*CREDIT_W +: CREDIT_W];
  end

  vending_stock #(
    .N_ITEMS(N_ITEMS), .STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK), .IDX_W(IDX_W)
  ) u_stock (
    .clk(clk), .rst(rst), .restock(state == IDLE && restock),
    .dec(dispense), .dec_idx(dispense_item), .empty(empty)
  );

  always_comb begin
    coin = coin_in != COIN_NONE;
    act = coin || select_valid || cancel;
    sum = {1'b0, credit} + (CREDIT_W+1)'(coin_in);
    fits = !sum[CREDIT_W];
    idx_ok = 32'(select_item) < N_ITEMS;
    sel_price = idx_ok ? price[select_item] : '0;
    sel_ok = idx_ok && !empty[select_item] && sel_price != '0 && credit >= sel_price;
    state_d = state;
    credit_d = credit;
    tmr_d = '0;
    coin_rej_d = 1'b0;
    sel_rej_d = 1'b0;
    if (state == IDLE) begin
      state_d = coin ? CREDIT : IDLE;
      credit_d = CREDIT_W'(coin_in);
    end else if (state == CREDIT) begin
      coin_rej_d = coin && !fits;
      credit_d = fits ? sum[CREDIT_W-1:0] : credit;
      tmr_d = act ? '0 : tmr + TW'(1);
      if (cancel) state_d = CHANGE;
      else if (select_valid && sel_ok) begin
        state_d = VEND;
        credit_d = credit_d - sel_price;
      end else if (select_valid) sel_rej_d = 1'b1;
      else if (!coin && tmr == TW'(TIMEOUT_CYC - 1)) state_d = CHANGE;
    end else if (state == VEND) begin
      coin_rej_d = coin;
      state_d = credit != '0 ? CHANGE : IDLE;
    end else begin
      coin_rej_d = coin;
      credit_d = credit - CREDIT_W'(1);
      state_d = credit == CREDIT_W'(1) ? IDLE : CHANGE;
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      credit <= '0;
      tmr <= '0;
      dispense <= 1'b0;
      dispense_item <= '0;
      return_change <= 1'b0;
      coin_reject <= 1'b0;
      sel_reject <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      credit <= credit_d;
      tmr <= tmr_d;
      dispense <= state_d == VEND;
      dispense_item <= state_d == VEND ? select_item : '0;
      return_change <= state_d == CHANGE;
      coin_reject <= coin_rej_d;
      sel_reject <= sel_rej_d;
      busy <= state_d == VEND || state_d == CHANGE;
    end
endmodule

// File: tb/tb_vending_ctrl.sv
// tb_vending_ctrl: directed and random stimulus checked against a queue-based purchase model
module tb_vending_ctrl;
  localparam int N = 5, CW = 3, SW = 2, IS = 1, TO = 20, IW = 3;
  localparam int MAXC = (1 << CW) - 1;
  localparam int NONE = -1, CHG = -2;
  logic clk = 0, rst;
  logic [1:0] coin_in;
  logic select_valid, cancel, restock;
  logic [IW-1:0] select_item;
  logic [N*CW-1:0] price_flat;
  logic dispense, return_change, coin_reject, sel_reject, busy;
  logic [IW-1:0] dispense_item;
  logic [CW-1:0] credit;
  int errors = 0, checks = 0;
  int prices [N];
  int m_credit, m_idle, cur;
  int m_stock [N];
  int q [$];
  bit e_crej, e_srej;

  vending_ctrl #(
    .N_ITEMS(N), .CREDIT_W(CW), .STOCK_W(SW), .INIT_STOCK(IS), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .coin_in(coin_in), .select_valid(select_valid),
    .select_item(select_item), .price_flat(price_flat), .cancel(cancel),
    .restock(restock), .dispense(dispense), .dispense_item(dispense_item),
    .return_change(return_change), .coin_reject(coin_reject),
    .sel_reject(sel_reject), .credit(credit), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, int expv);
    checks++;
    assert (obs === 32'(expv)) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic apply_prices();
    for (int i = 0; i < N; i++) price_flat[i*CW +: CW] = CW'(prices[i]);
  endtask

  function automatic void model_reset();
    m_credit = 0; m_idle = 0; cur = NONE; q.delete(); e_crej = 0; e_srej = 0;
    for (int i = 0; i < N; i++) m_stock[i] = IS;
  endfunction

  function automatic void refund();
    for (int k = 0; k < m_credit; k++) q.push_back(CHG);
  endfunction

  // One purchase-level step: the current cycle's inputs decide the next cycle's outputs.
  function automatic void model_step(int c, bit sv, int si, bit cn, bit rs);
    int sum, p;
    bit ok;
    e_crej = 0; e_srej = 0;
    if (cur != NONE) begin
      e_crej = c != 0;
      m_idle = 0;
      if (cur == CHG) m_credit--; else m_stock[cur]--;
    end else if (m_credit == 0) begin
      m_idle = 0;
      if (rs) for (int i = 0; i < N; i++) m_stock[i] = IS;
      m_credit = c;
    end else begin
      sum = m_credit + c;
      ok = sum <= MAXC;
      e_crej = !ok;
      p = si < N ? prices[si] : 0;
      if (cn) begin
        if (ok) m_credit = sum;
        refund();
      end else if (sv && si < N && m_stock[si] > 0 && p > 0 && m_credit >= p) begin
        m_credit = (ok ? sum : m_credit) - p;
        q.push_back(si);
        refund();
      end else begin
        if (ok) m_credit = sum;
        e_srej = sv;
        if (c != 0 || sv) m_idle = 0;
        else if (++m_idle == TO) begin
          m_idle = 0;
          refund();
        end
      end
    end
    cur = q.size() > 0 ? q.pop_front() : NONE;
  endfunction

  task automatic check_all();
    chk("dispense", dispense, cur >= 0);
    if (cur >= 0) chk("dispense_item", dispense_item, cur);
    chk("return_change", return_change, cur == CHG);
    chk("coin_reject", coin_reject, e_crej);
    chk("sel_reject", sel_reject, e_srej);
    chk("credit", credit, m_credit);
    chk("busy", busy, cur != NONE);
  endtask

  task automatic step(int c, bit sv = 0, int si = 0, bit cn = 0, bit rs = 0);
    coin_in = 2'(c); select_valid = sv; select_item = IW'(si); cancel = cn; restock = rs;
    model_step(c, sv, si, cn, rs);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && cur != NONE; k++) step(0);
    chk("drain_idle", busy, 0);
  endtask

  task automatic do_reset();
    coin_in = 0; select_valid = 0; select_item = 0; cancel = 0; restock = 0;
    rst = 0; #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    check_all();
    rst = 1;
  endtask

  initial begin
    int pulses;
    prices = '{2, 5, 1, 4, 0};
    apply_prices();
    do_reset();
    // coins 2,2,1 then item 3 at price 4: one dispense and one change pulse
    step(2); step(2); step(1);
    chk("t1.credit", credit, 5);
    step(0, 1, 3);
    chk("t1.dispense", dispense, 1);
    chk("t1.item", dispense_item, 3);
    step(0);
    chk("t1.change", return_change, 1);
    step(0);
    chk("t1.idle", busy, 0);
    // short credit then cancel
    step(3); step(0, 1, 1);
    chk("t2.sel_reject", sel_reject, 1);
    chk("t2.credit", credit, 3);
    step(0, 0, 0, 1);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      pulses += return_change;
      step(0);
    end
    chk("t2.pulses", pulses, 3);
    chk("t2.credit0", credit, 0);
    // sold out, restock, buy again
    step(2); step(0, 1, 0); drain();
    step(2); step(0, 1, 0);
    chk("t3.soldout", sel_reject, 1);
    step(0, 0, 0, 1); drain();
    step(0, 0, 0, 0, 1);
    step(2); step(0, 1, 0);
    chk("t3.restocked", dispense, 1);
    drain();
    // disabled and out-of-range items
    step(1); step(0, 1, 4);
    chk("t3.disabled", sel_reject, 1);
    step(0, 1, 6);
    chk("t3.range", sel_reject, 1);
    step(0, 0, 0, 1); drain();
    // overflow coin, then coins during VEND and CHANGE
    step(3); step(3); step(3);
    chk("t4.overflow", coin_reject, 1);
    chk("t4.credit", credit, 6);
    step(0, 1, 2); step(2);
    chk("t4.vend_coin", coin_reject, 1);
    step(2);
    chk("t4.change_coin", coin_reject, 1);
    drain();
    // inactivity timeout
    step(2);
    pulses = 0;
    for (int k = 0; k < TO + 4; k++) begin
      step(0);
      pulses += return_change;
    end
    chk("t5.timeout_pulses", pulses, 2);
    step(3); step(0, 1, 2, 1);
    chk("t5.cancel_wins", dispense, 0);
    chk("t5.cancel_change", return_change, 1);
    drain();
    // reset in the middle of CHANGE
    step(3); step(1); step(0, 0, 0, 1); step(0);
    chk("t6.mid_change", return_change, 1);
    do_reset();
    chk("t6.credit", credit, 0);
    step(3); step(1); step(0, 1, 3);
    chk("t6.stock_reloaded", dispense, 1);
    drain();
    // random traffic, alternating busy and quiet phases so timeouts also occur
    for (int n = 0; n < 3000; n++) begin
      bit quiet;
      int c;
      quiet = (n / 300) % 2 == 1;
      if ($urandom_range(0, 49) == 0) begin
        prices[$urandom_range(0, N-1)] = $urandom_range(0, MAXC);
        apply_prices();
      end
      if ($urandom_range(0, 499) == 0) do_reset();
      c = $urandom_range(0, quiet ? 40 : 2) == 0 ? $urandom_range(1, 3) : 0;
      step(c, $urandom_range(0, quiet ? 60 : 3) == 0, $urandom_range(0, 7),
           $urandom_range(0, quiet ? 200 : 30) == 0, $urandom_range(0, 9) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
